// File: rtl/proc_ctrl_pkg.sv
// Shared types and widths for the processor run controller.
package proc_ctrl_pkg;

  localparam int unsigned DataW = 64;
  localparam int unsigned CntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRst,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/run_watchdog.sv
// Saturating RUN-cycle counter with a limit-hit flag.
module run_watchdog
  import proc_ctrl_pkg::*;
#(
  parameter logic [CntW-1:0] Limit = 16'h00FF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            hit_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == Limit);

endmodule

// File: rtl/proc_run_ctrl.sv
// Sequences one processor run: reset pulse, watchdog-bounded run, result compare.
// Optional scoreboard counters (pass_cnt/run_cnt) under PROC_RUN_CTRL_SCORE_EN.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter logic [CntW-1:0] WD_LIMIT   = 16'h00FF,
  parameter int unsigned     RST_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [DataW-1:0] start_pc,
  input  logic [DataW-1:0] end_pc,
  input  logic [DataW-1:0] expected,
  input  logic [DataW-1:0] currentpc,
  input  logic [DataW-1:0] memtoreg,
`ifdef PROC_RUN_CTRL_SCORE_EN
  output logic [7:0]       pass_cnt,
  output logic [7:0]       run_cnt,
`endif
  output logic             proc_resetl,
  output logic [DataW-1:0] proc_startpc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [DataW-1:0] result,
  output logic [CntW-1:0]  cycle_cnt
);

  localparam int unsigned RstW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);

  state_e           state_d, state_q;
  logic [RstW-1:0]  rst_cnt_d, rst_cnt_q;
  logic [DataW-1:0] startpc_d, startpc_q;
  logic [DataW-1:0] end_pc_d, end_pc_q;
  logic [DataW-1:0] expected_d, expected_q;
  logic [DataW-1:0] result_d, result_q;
  logic             pass_d, pass_q;
  logic             timeout_d, timeout_q;
  logic             wd_clear, wd_en, wd_hit;
  logic             end_hit;

  assign end_hit = (currentpc >= end_pc_q);

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = '0;
    startpc_d  = startpc_q;
    end_pc_d   = end_pc_q;
    expected_d = expected_q;
    result_d   = result_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          startpc_d  = start_pc;
          end_pc_d   = end_pc;
          expected_d = expected;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          wd_clear   = 1'b1;
          state_d    = StRst;
        end
      end
      StRst: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // End condition takes priority over the watchdog in the same cycle.
        if (end_hit) begin
          result_d = memtoreg;
          pass_d   = (memtoreg == expected_q);
          state_d  = StDone;
        end else if (wd_hit) begin
          result_d  = memtoreg;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wd_en = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rst_cnt_q  <= '0;
      startpc_q  <= '0;
      end_pc_q   <= '0;
      expected_q <= '0;
      result_q   <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      startpc_q  <= startpc_d;
      end_pc_q   <= end_pc_d;
      expected_q <= expected_d;
      result_q   <= result_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  run_watchdog #(
    .Limit (WD_LIMIT)
  ) u_run_watchdog (
    .clk_i   (CLK),
    .rst_i   (reset),
    .clear_i (wd_clear),
    .en_i    (wd_en),
    .cnt_o   (cycle_cnt),
    .hit_o   (wd_hit)
  );

`ifdef PROC_RUN_CTRL_SCORE_EN
  logic [7:0] pass_cnt_d, pass_cnt_q;
  logic [7:0] run_cnt_d, run_cnt_q;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    run_cnt_d  = run_cnt_q;
    if (state_q == StDone) begin
      run_cnt_d = run_cnt_q + 8'd1;
      if (pass_q) begin
        pass_cnt_d = pass_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pass_cnt_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign run_cnt  = run_cnt_q;
`endif

  assign proc_resetl  = (state_q == StRun);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign proc_startpc = startpc_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign result       = result_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Randomized bench for proc_run_ctrl against a run-level reference model.
module tb_proc_run_ctrl;

  localparam int unsigned WD   = 255;
  localparam int unsigned RSTC = 2;

  logic        CLK = 1'b0;
  logic        reset, start;
  logic [63:0] start_pc, end_pc, expected, currentpc, memtoreg;
  logic        proc_resetl, busy, done, pass, timeout;
  logic [63:0] proc_startpc, result;
  logic [15:0] cycle_cnt;
`ifdef PROC_RUN_CTRL_SCORE_EN
  logic [7:0]  pass_cnt, run_cnt;
`endif

  proc_run_ctrl #(
    .WD_LIMIT   (16'(WD)),
    .RST_CYCLES (RSTC)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .start_pc     (start_pc),
    .end_pc       (end_pc),
    .expected     (expected),
    .currentpc    (currentpc),
    .memtoreg     (memtoreg),
`ifdef PROC_RUN_CTRL_SCORE_EN
    .pass_cnt     (pass_cnt),
    .run_cnt      (run_cnt),
`endif
    .proc_resetl  (proc_resetl),
    .proc_startpc (proc_startpc),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .result       (result),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 CLK = ~CLK;

  // Toy processor: PC parked at the start address in reset, then strides.
  logic [63:0] stride, mem_base, mix_mask, pc_q;
  always @(posedge CLK) begin
    if (proc_resetl !== 1'b1) pc_q <= proc_startpc;
    else                      pc_q <= pc_q + stride;
  end
  assign currentpc = pc_q;
  assign memtoreg  = mem_base ^ (pc_q & mix_mask);

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] cur_s, cur_e, cur_x;
  logic [7:0]  m_runs   = 8'd0;
  logic [7:0]  m_passes = 8'd0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // k = index of the terminating RUN cycle; PC in RUN cycle i is s + d*i.
  function automatic void ref_run(input logic [63:0] s, e, d, base, mask,
                                  output int unsigned k, output bit to,
                                  output logic [63:0] term);
    k  = WD;
    to = 1'b1;
    for (int unsigned i = 0; i <= WD; i++) begin
      if (s + d * 64'(i) >= e) begin
        k  = i;
        to = 1'b0;
        break;
      end
    end
    term = base ^ ((s + d * 64'(k)) & mask);
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first RST cycle.
  task automatic start_run(input logic [63:0] s, e, x);
    cur_s = s; cur_e = e; cur_x = x;
    start_pc = s; end_pc = e; expected = x;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_resetl", proc_resetl, 0);
    check_eq("accept_startpc", proc_startpc, s);
    check_eq("accept_cnt_clr", cycle_cnt, 0);
    check_eq("accept_pass_clr", pass, 0);
    check_eq("accept_to_clr", timeout, 0);
  endtask

  task automatic finish_run(input bit poke, input bit start_in_done);
    int unsigned k;
    bit          to, exp_pass;
    logic [63:0] term;
    int unsigned rst_lo = 0, run_cy = 0, guard = 0;
    ref_run(cur_s, cur_e, stride, mem_base, mix_mask, k, to, term);
    exp_pass = !to && (term == cur_x);
    while (done !== 1'b1 && guard < 4000) begin
      if (proc_resetl === 1'b1) run_cy++;
      else                      rst_lo++;
      start = poke && (guard == 4);
      @(negedge CLK);
      guard++;
    end
    start = 1'b0;
    check_eq("done_seen", done, 1);
    check_eq("rst_low_cycles", rst_lo, RSTC);
    check_eq("run_cycles", run_cy, k + 1);
    check_eq("done_resetl", proc_resetl, 0);
    check_eq("done_busy", busy, 1);
    check_eq("pass", pass, exp_pass);
    check_eq("timeout", timeout, to);
    check_eq("result", result, term);
    check_eq("cycle_cnt", cycle_cnt, k);
    m_runs++;
    if (exp_pass) m_passes++;
    if (start_in_done) start = 1'b1;
    @(negedge CLK);
    check_eq("idle_busy", busy, 0);
    check_eq("done_pulse_width", done, 0);
    check_eq("hold_pass", pass, exp_pass);
    check_eq("hold_timeout", timeout, to);
    check_eq("hold_result", result, term);
    check_eq("hold_cycle_cnt", cycle_cnt, k);
`ifdef PROC_RUN_CTRL_SCORE_EN
    check_eq("run_cnt", run_cnt, m_runs);
    check_eq("pass_cnt", pass_cnt, m_passes);
`endif
  endtask

  task automatic check_zeroed(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pass"}, pass, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_result"}, result, 0);
    check_eq({tag, "_cycle_cnt"}, cycle_cnt, 0);
    check_eq({tag, "_resetl"}, proc_resetl, 0);
    check_eq({tag, "_startpc"}, proc_startpc, 0);
`ifdef PROC_RUN_CTRL_SCORE_EN
    check_eq({tag, "_run_cnt"}, run_cnt, 0);
    check_eq({tag, "_pass_cnt"}, pass_cnt, 0);
`endif
  endtask

  initial begin
    logic [63:0] s, e, x, term;
    int unsigned k, seen;
    bit          to;
    reset = 1'b1; start = 1'b0;
    start_pc = '0; end_pc = '0; expected = '0;
    stride = 64'd4; mem_base = '0; mix_mask = '0;
    repeat (2) @(negedge CLK);
    check_zeroed("reset");
    reset = 1'b0;
    @(negedge CLK);

    // Golden run, then same run with a wrong expected value; start held through DONE.
    mem_base = 64'h1234_5678_9abc_def0;
    start_run(64'h0, 64'h54, mem_base);
    finish_run(1'b0, 1'b1);
    start_run(64'h0, 64'h54, 64'h0);
    finish_run(1'b0, 1'b0);

    // Stuck PC runs into the watchdog; a start poked mid-run must be ignored.
    stride = 64'd0;
    start_run(64'h10, 64'h100, mem_base);
    finish_run(1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    check_eq("no_extra_run", busy, 0);

    // End reached in the very cycle the watchdog limit is hit.
    stride = 64'd4;
    start_run(64'h0, 64'(WD * 4), mem_base);
    finish_run(1'b0, 1'b0);

    repeat (12) begin
      stride   = 64'($urandom_range(0, 12));
      s        = 64'h1000 + 64'($urandom);
      if ($urandom_range(0, 3) == 0) e = s - 64'($urandom_range(0, 64));
      else                           e = s + 64'($urandom_range(0, 1100));
      mem_base = {$urandom, $urandom};
      mix_mask = ($urandom_range(0, 1) == 1) ? '1 : '0;
      ref_run(s, e, stride, mem_base, mix_mask, k, to, term);
      x = ($urandom_range(0, 1) == 1) ? term : {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      start_run(s, e, x);
      finish_run($urandom_range(0, 1) == 1, 1'b0);
    end

    // Asynchronous reset in the middle of RUN, with start held high.
    stride = 64'd0;
    start_run(64'h20, 64'h1000, 64'h0);
    repeat (10) @(negedge CLK);
    start = 1'b1;
    #2 reset = 1'b1;
    #1 check_zeroed("midrun");
    start = 1'b0;
    m_runs = 8'd0;
    m_passes = 8'd0;
    @(negedge CLK);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    check_eq("post_reset_idle", seen, 0);

    // Recovery run after the abort.
    stride = 64'd4;
    mem_base = 64'hdead_beef_0000_0001;
    mix_mask = '0;
    start_run(64'h100, 64'h140, mem_base);
    finish_run(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
